// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard/redirect sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    PCTRL_RUN  = 2'd0,
    PCTRL_PEND = 2'd1,
    PCTRL_HOLD = 2'd2
  } pctrl_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  // addi x0, x0, 0 -- what the flushed IF/ID and ID/EX stages load
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect sequencer: arbitrates jumps, execute holds, load-use
// bubbles and bus stalls into hold/flush/redirect controls for the front end.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  input  logic             hold_flag_i,
  input  logic             load_use_i,
  input  logic             bus_stall_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             id_ex_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             redirect_en_o,
  output logic [31:0]      redirect_addr_o,
  output logic             hold_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [7:0] TIMEOUT = 8'(HOLD_TIMEOUT);

  pctrl_state_e state, state_next;
  logic [31:0]  pend_addr;
  logic [7:0]   hold_cnt, hold_cnt_next;
  logic         latch_pend;
  logic         run_rules;

  always_comb begin
    pc_hold_o       = 1'b0;
    if_id_hold_o    = 1'b0;
    id_ex_hold_o    = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_flush_o   = 1'b0;
    redirect_en_o   = 1'b0;
    redirect_addr_o = ZERO_WORD;
    state_next      = state;
    hold_cnt_next   = hold_cnt;
    latch_pend      = 1'b0;
    run_rules       = 1'b0;

    case (state)
      PCTRL_PEND: begin
        if (bus_stall_i) begin
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_flush_o = 1'b1;
        end else begin
          redirect_en_o   = 1'b1;
          redirect_addr_o = pend_addr;
          if_id_flush_o   = 1'b1;
          id_ex_flush_o   = 1'b1;
          state_next      = PCTRL_RUN;
        end
      end
      PCTRL_HOLD: begin
        if (hold_flag_i) begin
          pc_hold_o     = 1'b1;
          if_id_hold_o  = 1'b1;
          id_ex_hold_o  = 1'b1;
          hold_cnt_next = (hold_cnt == 8'hFF) ? 8'hFF : hold_cnt + 8'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      default: run_rules = 1'b1;
    endcase

    // Release from EX_HOLD falls through here in the same cycle (Mealy)
    if (run_rules) begin
      state_next    = PCTRL_RUN;
      hold_cnt_next = 8'd0;
      if (bus_stall_i && jump_en_i) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
        latch_pend    = 1'b1;
        state_next    = PCTRL_PEND;
      end else if (jump_en_i) begin
        redirect_en_o   = 1'b1;
        redirect_addr_o = jump_addr_i;
        if_id_flush_o   = 1'b1;
        id_ex_flush_o   = 1'b1;
      end else if (bus_stall_i) begin
        pc_hold_o    = 1'b1;
        if_id_hold_o = 1'b1;
        id_ex_hold_o = 1'b1;
      end else if (hold_flag_i) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_hold_o  = 1'b1;
        state_next    = PCTRL_HOLD;
        hold_cnt_next = 8'd1;
      end else if (load_use_i) begin
        pc_hold_o     = 1'b1;
        if_id_hold_o  = 1'b1;
        id_ex_flush_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PCTRL_RUN;
      pend_addr   <= ZERO_WORD;
      hold_cnt    <= 8'd0;
      hold_err_o  <= 1'b0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
      if (latch_pend)
        pend_addr <= jump_addr_i;
      if (hold_cnt_next >= TIMEOUT)
        hold_err_o <= 1'b1;
      if (pc_hold_o)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (redirect_en_o)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: expected per-cycle outputs are queued as
// stimulus is driven and compared against the DUT at the following negedge.
module tb_pipeline_ctrl;

  localparam int HOLD_TIMEOUT = 16;
  localparam int CNT_W        = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_i = 1'b0;
  logic        load_use_i = 1'b0;
  logic        bus_stall_i = 1'b0;
  logic        pc_hold_o, if_id_hold_o, id_ex_hold_o;
  logic        if_id_flush_o, id_ex_flush_o, redirect_en_o, hold_err_o;
  logic [31:0] redirect_addr_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  pipeline_ctrl #(.HOLD_TIMEOUT(HOLD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .load_use_i(load_use_i), .bus_stall_i(bus_stall_i),
    .pc_hold_o(pc_hold_o), .if_id_hold_o(if_id_hold_o), .id_ex_hold_o(id_ex_hold_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .redirect_en_o(redirect_en_o), .redirect_addr_o(redirect_addr_o),
    .hold_err_o(hold_err_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  // ctl = {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, redirect_en}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic        err;
    logic [31:0] stall;
    logic [31:0] flush;
  } obs_t;

  // st = {jump_en, hold_flag, load_use, bus_stall}
  typedef struct packed {
    logic [3:0]  st;
    logic [31:0] jaddr;
    logic [5:0]  ctl;
    logic [31:0] raddr;
    logic        err;
  } vec_t;

  obs_t obs, exp_v;
  obs_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] tally_stall = 32'h0;
  logic [31:0] tally_flush = 32'h0;

  assign obs = {pc_hold_o, if_id_hold_o, id_ex_hold_o, if_id_flush_o, id_ex_flush_o,
                redirect_en_o, redirect_addr_o, hold_err_o, stall_cnt_o, flush_cnt_o};

  task automatic apply(input vec_t v);
    obs_t e;
    @(posedge clk); #1;
    {jump_en_i, hold_flag_i, load_use_i, bus_stall_i} = v.st;
    jump_addr_i = v.jaddr;
    e.ctl   = v.ctl;
    e.addr  = v.raddr;
    e.err   = v.err;
    e.stall = tally_stall;
    e.flush = tally_flush;
    sb.push_back(e);
    tally_stall = tally_stall + {31'h0, v.ctl[5]};
    tally_flush = tally_flush + {31'h0, v.ctl[0]};
  endtask

  task automatic test_reset();
    obs_t e;
    @(posedge clk); #3;
    rst_n = 1'b0;
    {jump_en_i, hold_flag_i, load_use_i, bus_stall_i} = 4'b0000;
    jump_addr_i = 32'h0;
    tally_stall = 32'h0;
    tally_flush = 32'h0;
    e = '0;
    sb.push_back(e);
    #1;
    exp_v = sb.pop_front();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset got %h exp %h", obs, exp_v);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic run_table(input string name, input vec_t v[$]);
    foreach (v[i]) begin
      apply(v[i]);
      @(negedge clk);
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL %s[%0d] scoreboard empty", name, i);
      end else begin
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
          miscompares++;
          $display("FAIL %s[%0d] got %h exp %h", name, i, obs, exp_v);
        end
      end
    end
  endtask

  task automatic test_jump();
    vec_t v[$];
    v.push_back('{4'b1000, 32'h100, 6'b000111, 32'h100, 1'b0});
    v.push_back('{4'b0000, 32'h0,   6'b000000, 32'h0,   1'b0});
    run_table("jump", v);
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back('{4'b1000, 32'h10, 6'b000111, 32'h10, 1'b0});
    v.push_back('{4'b1000, 32'h20, 6'b000111, 32'h20, 1'b0});
    v.push_back('{4'b0001, 32'h0,  6'b111000, 32'h0,  1'b0});
    v.push_back('{4'b0000, 32'h0,  6'b000000, 32'h0,  1'b0});
    run_table("back_to_back", v);
  endtask

  task automatic test_stall_jump();
    vec_t v[$];
    v.push_back('{4'b1001, 32'h200, 6'b110010, 32'h0,   1'b0});
    v.push_back('{4'b1001, 32'h999, 6'b110010, 32'h0,   1'b0});
    v.push_back('{4'b0001, 32'h0,   6'b110010, 32'h0,   1'b0});
    v.push_back('{4'b0000, 32'h0,   6'b000111, 32'h200, 1'b0});
    v.push_back('{4'b0000, 32'h0,   6'b000000, 32'h0,   1'b0});
    run_table("stall_jump", v);
  endtask

  task automatic test_hold_short();
    vec_t v[$];
    for (int i = 0; i < 5; i++)
      v.push_back('{4'b0100, 32'h0, 6'b111000, 32'h0, 1'b0});
    v.push_back('{4'b0000, 32'h0, 6'b000000, 32'h0, 1'b0});
    v.push_back('{4'b0010, 32'h0, 6'b110010, 32'h0, 1'b0});
    run_table("hold_short", v);
  endtask

  task automatic test_hold_timeout();
    vec_t v[$];
    for (int i = 1; i <= 20; i++)
      v.push_back('{4'b0100, 32'h0, 6'b111000, 32'h0, (i > HOLD_TIMEOUT)});
    for (int i = 0; i < 3; i++)
      v.push_back('{4'b0000, 32'h0, 6'b000000, 32'h0, 1'b1});
    run_table("hold_timeout", v);
  endtask

  task automatic test_load_use();
    vec_t v[$];
    v.push_back('{4'b0010, 32'h0,   6'b110010, 32'h0,   1'b0});
    v.push_back('{4'b0000, 32'h0,   6'b000000, 32'h0,   1'b0});
    v.push_back('{4'b1010, 32'h180, 6'b000111, 32'h180, 1'b0});
    v.push_back('{4'b0000, 32'h0,   6'b000000, 32'h0,   1'b0});
    run_table("load_use", v);
  endtask

  task automatic test_hold_release();
    vec_t v[$];
    v.push_back('{4'b0100, 32'h0,  6'b111000, 32'h0,  1'b0});
    v.push_back('{4'b0101, 32'h0,  6'b111000, 32'h0,  1'b0});
    v.push_back('{4'b1000, 32'h40, 6'b000111, 32'h40, 1'b0});
    v.push_back('{4'b0100, 32'h0,  6'b111000, 32'h0,  1'b0});
    v.push_back('{4'b0001, 32'h0,  6'b111000, 32'h0,  1'b0});
    v.push_back('{4'b0000, 32'h0,  6'b000000, 32'h0,  1'b0});
    run_table("hold_release", v);
  endtask

  task automatic test_reset_pend();
    vec_t v[$];
    vec_t w[$];
    v.push_back('{4'b1001, 32'h300, 6'b110010, 32'h0, 1'b0});
    v.push_back('{4'b0001, 32'h0,   6'b110010, 32'h0, 1'b0});
    run_table("reset_pend_pre", v);
    test_reset();
    w.push_back('{4'b0000, 32'h0, 6'b000000, 32'h0, 1'b0});
    w.push_back('{4'b0000, 32'h0, 6'b000000, 32'h0, 1'b0});
    run_table("reset_pend_post", w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    test_reset();
    test_jump();
    test_back_to_back();
    test_reset();
    test_stall_jump();
    test_reset();
    test_hold_short();
    test_hold_timeout();
    test_reset();
    test_load_use();
    test_hold_release();
    test_reset_pend();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover scoreboard entries %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and redirect sequencer for the 5-stage RV32I core. It collects jump/branch decisions and multi-cycle hold requests from the execute stage, load-use hazards from decode, and stall from the instruction/data bus. It drives hold, flush and PC-redirect controls to pc_reg, if_id and id_ex. It holds a deferred redirect across bus stalls, guards holds with a timeout, and keeps stall and flush performance counters.

Parameters:
HOLD_TIMEOUT, 16, max consecutive cycles an execute hold may last before hold_err_o asserts (2..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
jump_en_i  in  1  execute-stage redirect request (branch taken, JAL, JALR)
jump_addr_i  in  32  redirect target; valid when jump_en_i=1
hold_flag_i  in  1  execute stage requests a pipeline hold (multi-cycle op)
load_use_i  in  1  decode detected load-use hazard
bus_stall_i  in  1  bus not ready; fetch/memory must not advance
pc_hold_o  out  1  freeze PC
if_id_hold_o  out  1  freeze IF/ID register
id_ex_hold_o  out  1  freeze ID/EX register
if_id_flush_o  out  1  load NOP into IF/ID
id_ex_flush_o  out  1  load NOP into ID/EX
redirect_en_o  out  1  PC loads redirect_addr_o this cycle
redirect_addr_o  out  32  PC redirect target
hold_err_o  out  1  sticky: hold exceeded HOLD_TIMEOUT
stall_cnt_o  out  CNT_W  cycles with pc_hold_o=1
flush_cnt_o  out  CNT_W  redirects applied

Behaviour:
- Reset (rst_n=0, async): state=RUN, pending redirect cleared, hold counter=0, hold_err_o=0, both counters=0. All combinational outputs evaluate to 0 in RUN with inputs low.
- States: RUN, PEND_JUMP, EX_HOLD.
- RUN, priority high to low:
  1. bus_stall_i=1 with jump_en_i=1: latch jump_addr_i into pend_addr. Assert pc_hold_o and if_id_hold_o. Assert id_ex_flush_o (kills the younger instruction entering EX). Next state PEND_JUMP.
  2. jump_en_i=1 (no stall): redirect_en_o=1, redirect_addr_o=jump_addr_i, if_id_flush_o=1, id_ex_flush_o=1. Holds 0, zero latency, same cycle. flush_cnt +1.
  3. bus_stall_i=1: pc_hold_o, if_id_hold_o and id_ex_hold_o all 1.
  4. hold_flag_i=1: all three holds 1. Next state EX_HOLD. Hold counter=1.
  5. load_use_i=1: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1 (bubble). Single cycle, stays RUN.
- PEND_JUMP:
  - While bus_stall_i=1: pc_hold_o=1, if_id_hold_o=1, id_ex_flush_o=1.
  - First cycle with bus_stall_i=0: redirect_en_o=1, redirect_addr_o=pend_addr, both flushes 1, flush_cnt +1, next RUN.
  - jump_en_i in this state is ignored; the bubbled EX cannot branch.
- EX_HOLD:
  - Holds all 1 while hold_flag_i=1. Hold counter increments, saturating at 255.
  - When the counter reaches HOLD_TIMEOUT, hold_err_o sets and stays set until reset. The hold is still honoured.
  - hold_flag_i=0: next RUN, counter=0. jump_en_i on the release cycle is processed by RUN rules that same cycle; decode is combinational on state, so the FSM is Mealy on release.
  - bus_stall_i during EX_HOLD: holds stay 1 and the state is unchanged.
- A flush and a hold on the same register never both assert. Flush wins only where listed above.
- stall_cnt increments every cycle pc_hold_o=1. Both counters wrap modulo 2^CNT_W with no saturation.
- Reset mid-PEND_JUMP discards pend_addr; no redirect is issued after reset.

Decomposition:
- Shared defines file: state encodings (PCTRL_RUN=2'd0, PCTRL_PEND=2'd1, PCTRL_HOLD=2'd2), ZERO_WORD, NOP instruction constant used by the flushed stages.
- No sub-module needed. The FSM, the hold counter and the two counters fit in one module. Counters may be factored into a small perf_counter module if reused by the CSR block.

Test Plan:
- Reset, then jump_en_i=1, jump_addr_i=0x0000_0100 → same cycle redirect_en_o=1, redirect_addr_o=0x100, if_id_flush_o=id_ex_flush_o=1, flush_cnt_o=1 next cycle.
- bus_stall_i=1 for 3 cycles with jump_en_i=1 (addr 0x200) on the first → pc_hold_o=1 for 3 cycles, no redirect during stall, redirect_en_o=1 with addr 0x200 on the cycle stall drops, stall_cnt_o=3.
- hold_flag_i=1 for 5 cycles, HOLD_TIMEOUT=16 → all holds 1 for 5 cycles, hold_err_o=0, state returns RUN.
- hold_flag_i=1 for 20 cycles, HOLD_TIMEOUT=16 → hold_err_o rises after the 16th hold cycle and remains 1 after release until rst_n pulse.
- load_use_i=1 for one cycle → pc_hold_o=if_id_hold_o=id_ex_flush_o=1 for exactly 1 cycle; load_use_i together with jump_en_i → jump rules only.
- Assert rst_n=0 asynchronously mid-PEND_JUMP (addr 0x300), release with bus_stall_i=0 → no redirect, all outputs and counters 0.
